dmem_bytelane: RTL and testbench

Parametrised successor data memory for the CPU load/store path. Byte-addressed, single-port, little-endian; supports byte/half/word stores with correct lane placement and sign/zero-extending loads. Valid/ready request side, in-order response pipeline of configurable read latency. Sits between the EX/MEM stage and the word-organised storage array.

---
 rtl/dmem_pkg.sv | 36 +++
 rtl/dmem_bytelane_if.sv | 21 ++
 rtl/dmem_rsp_pipe.sv | 33 +++
 rtl/dmem_bytelane.sv | 68 ++++++
 tb/tb_dmem_bytelane.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: size encodings, lane byte-enables, store lane placement and load extension
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef struct packed {
    logic       valid;
    logic       err;
    logic       we;
    size_e      size;
    logic       uns;
    logic [1:0] lane;
  } rsp_ctrl_t;

  function automatic logic [3:0] lane_be(size_e sz, logic [1:0] lane);
    return sz == SZ_BYTE ? 4'b0001 << lane : sz == SZ_HALF ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction

  function automatic logic [31:0] lane_data(size_e sz, logic [31:0] wd);
    return sz == SZ_BYTE ? {4{wd[7:0]}} : sz == SZ_HALF ? {2{wd[15:0]}} : wd;
  endfunction

  function automatic logic [31:0] load_extend(size_e sz, logic uns, logic [1:0] lane, logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    return sz == SZ_BYTE ? {{24{~uns & b[7]}}, b} : sz == SZ_HALF ? {{16{~uns & h[15]}}, h} : word;
  endfunction

endpackage

// File: rtl/dmem_bytelane_if.sv
// dmem_bytelane_if: request/response bus between the load/store unit and dmem_bytelane
interface dmem_bytelane_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  modport master(
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave(
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_rsp_pipe.sv
// dmem_rsp_pipe: RD_LAT-deep control/data shift pipeline with synchronous clear
module dmem_rsp_pipe
  import dmem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  rsp_ctrl_t   in_ctrl,
  input  logic [31:0] in_data,
  output rsp_ctrl_t   out_ctrl,
  output logic [31:0] out_data
);
  rsp_ctrl_t   ctrl_q [RD_LAT];
  logic [31:0] data_q [RD_LAT];

  // advance one stage per cycle; reset drops everything in flight
  always_ff @(posedge clk)
    if (rst) begin
      ctrl_q <= '{default: '0};
      data_q <= '{default: '0};
    end else begin
      ctrl_q[0] <= in_ctrl;
      data_q[0] <= in_data;
      for (int i = 1; i < RD_LAT; i++) begin
        ctrl_q[i] <= ctrl_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end

  assign out_ctrl = ctrl_q[RD_LAT-1];
  assign out_data = data_q[RD_LAT-1];
endmodule

// File: rtl/dmem_bytelane.sv
// dmem_bytelane: byte-lane data memory with valid/ready requests and RD_LAT-cycle in-order responses
// Build option DMEM_ALIGN_CHK_EN: flag misaligned/reserved-size requests; otherwise force natural alignment.
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LAT      = 1
) (
  input logic           clk,
  input logic           rst,
  dmem_bytelane_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]      mem [DEPTH_WORDS];
  logic             accept;
  logic [IDX_W-1:0] idx;
  size_e            size;
  logic [1:0]       lane;
  logic             err;
  logic [3:0]       be;
  logic [31:0]      wd;
  rsp_ctrl_t        in_ctrl;
  rsp_ctrl_t        out_ctrl;
  logic [31:0]      out_data;
  logic             unused_addr;

  assign bus.req_ready = !rst;
  assign accept        = bus.req_valid && !rst;
  assign idx           = bus.req_addr[IDX_W+1:2];
  assign unused_addr   = ^bus.req_addr[ADDR_W-1:IDX_W+2];

`ifdef DMEM_ALIGN_CHK_EN
  assign size = size_e'(bus.req_size);
  assign lane = bus.req_addr[1:0];
  assign err  = size == SZ_RSVD || (size == SZ_HALF && lane[0]) || (size == SZ_WORD && lane != 2'd0);
`else
  assign size = bus.req_size == SZ_RSVD ? SZ_WORD : size_e'(bus.req_size);
  assign lane = size == SZ_BYTE ? bus.req_addr[1:0] : size == SZ_HALF ? {bus.req_addr[1], 1'b0} : 2'd0;
  assign err  = 1'b0;
`endif

  assign be = lane_be(size, lane);
  assign wd = lane_data(size, bus.req_wdata);

  // store: write only the addressed lanes; rejected requests write nothing
  always_ff @(posedge clk)
    if (accept && bus.req_we && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];

  assign in_ctrl = '{valid: accept, err: err, we: bus.req_we, size: size, uns: bus.req_unsigned, lane: lane};

  dmem_rsp_pipe #(.RD_LAT(RD_LAT)) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_ctrl  (in_ctrl),
    .in_data  (mem[idx]),
    .out_ctrl (out_ctrl),
    .out_data (out_data)
  );

  assign bus.rsp_valid = !rst && out_ctrl.valid;
  assign bus.rsp_err   = bus.rsp_valid && out_ctrl.err;
  assign bus.rsp_rdata = bus.rsp_valid && !out_ctrl.err && !out_ctrl.we ?
                         load_extend(out_ctrl.size, out_ctrl.uns, out_ctrl.lane, out_data) : '0;
endmodule

// File: tb/tb_dmem_bytelane.sv
// tb_dmem_bytelane: directed load/store vectors checked by a response scoreboard
module tb_dmem_bytelane;
  import dmem_pkg::*;
  localparam int LAT = 3;

  typedef struct {
    int          due;
    int          id;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   nid = 0;
  exp_t q[$];

  dmem_bytelane_if #(.ADDR_W(32)) bus();

  dmem_bytelane #(.ADDR_W(32), .DEPTH_WORDS(1024), .RD_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (q.size() != 0 && q[0].due == cyc) begin
      chk($sformatf("rsp%0d_valid", q[0].id), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("rsp%0d_rdata", q[0].id), bus.rsp_rdata, q[0].rdata);
      chk($sformatf("rsp%0d_err", q[0].id), 32'(bus.rsp_err), 32'(q[0].err));
      void'(q.pop_front());
    end else if (bus.rsp_valid) chk($sformatf("spurious_rsp_c%0d", cyc), 32'(bus.rsp_valid), 32'd0);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] er, input logic ee);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    q.push_back('{due: cyc + LAT, id: nid, rdata: er, err: ee});
    nid++;
    step();
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd, input logic ee);
    req(1'b1, sz, 1'b0, a, wd, 32'h0, ee);
  endtask

  task automatic ld(input logic [1:0] sz, input logic uns, input logic [31:0] a, input logic [31:0] er, input logic ee);
    req(1'b0, sz, uns, a, 32'h0, er, ee);
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic chk_rst_outputs(input string tag);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rdata"}, bus.rsp_rdata, 32'd0);
    chk({tag, "_err"}, 32'(bus.rsp_err), 32'd0);
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = SZ_WORD;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    repeat (3) step();
    @(negedge clk);
    chk_rst_outputs("reset");
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.req_ready), 32'd1);
    step();

    st(SZ_WORD, 32'h10, 32'hDEADBEEF, 1'b0);
    ld(SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    st(SZ_BYTE, 32'h12, 32'h00000055, 1'b0);
    ld(SZ_WORD, 1'b0, 32'h10, 32'hDE55BEEF, 1'b0);
    ld(SZ_BYTE, 1'b0, 32'h13, 32'hFFFFFFDE, 1'b0);
    ld(SZ_BYTE, 1'b1, 32'h13, 32'h000000DE, 1'b0);
    st(SZ_WORD, 32'h20, 32'h00000000, 1'b0);
    st(SZ_HALF, 32'h22, 32'h12348001, 1'b0);
    ld(SZ_WORD, 1'b0, 32'h20, 32'h80010000, 1'b0);
    ld(SZ_HALF, 1'b0, 32'h22, 32'hFFFF8001, 1'b0);
    ld(SZ_HALF, 1'b1, 32'h22, 32'h00008001, 1'b0);
    ld(SZ_HALF, 1'b0, 32'h20, 32'h00000000, 1'b0);
    ld(SZ_BYTE, 1'b0, 32'h23, 32'hFFFFFF80, 1'b0);
    ld(SZ_BYTE, 1'b1, 32'h22, 32'h00000001, 1'b0);
    st(SZ_BYTE, 32'h21, 32'hAABBCC77, 1'b0);
    ld(SZ_WORD, 1'b1, 32'h20, 32'h80017700, 1'b0);
    st(SZ_WORD, 32'h1000, 32'hCAFEF00D, 1'b0);
    ld(SZ_WORD, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0);
    ld(SZ_HALF, 1'b0, 32'h2, 32'hFFFFCAFE, 1'b0);
    idle(2);
    for (int i = 0; i < 8; i++) st(SZ_WORD, 32'h100 + 32'(4 * i), 32'hA0000000 | 32'(i), 1'b0);
    for (int i = 0; i < 8; i++) ld(SZ_WORD, 1'b0, 32'h100 + 32'(4 * i), 32'hA0000000 | 32'(i), 1'b0);
    idle(LAT + 1);

`ifdef DMEM_ALIGN_CHK_EN
    st(SZ_WORD, 32'h11, 32'h11111111, 1'b1);
    ld(SZ_WORD, 1'b0, 32'h10, 32'hDE55BEEF, 1'b0);
    ld(SZ_HALF, 1'b0, 32'h13, 32'h00000000, 1'b1);
    ld(SZ_RSVD, 1'b0, 32'h10, 32'h00000000, 1'b1);
    st(SZ_RSVD, 32'h10, 32'h22222222, 1'b1);
    st(SZ_HALF, 32'h11, 32'h00003333, 1'b1);
    ld(SZ_WORD, 1'b0, 32'h10, 32'hDE55BEEF, 1'b0);
`else
    st(SZ_WORD, 32'h11, 32'h11111111, 1'b0);
    ld(SZ_WORD, 1'b0, 32'h10, 32'h11111111, 1'b0);
    ld(SZ_HALF, 1'b0, 32'h13, 32'h00001111, 1'b0);
    st(SZ_HALF, 32'h13, 32'h0000BEEF, 1'b0);
    ld(SZ_RSVD, 1'b0, 32'h12, 32'hBEEF1111, 1'b0);
    ld(SZ_HALF, 1'b1, 32'h13, 32'h0000BEEF, 1'b0);
    st(SZ_RSVD, 32'h13, 32'h76543210, 1'b0);
    ld(SZ_WORD, 1'b0, 32'h10, 32'h76543210, 1'b0);
`endif
    idle(LAT + 1);

    ld(SZ_WORD, 1'b0, 32'h100, 32'hA0000000, 1'b0);
    st(SZ_WORD, 32'h104, 32'h5555AAAA, 1'b0);
    q.delete();
    rst              = 1'b1;
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b1;
    bus.req_size     = SZ_WORD;
    bus.req_addr     = 32'h100;
    bus.req_wdata    = 32'hFFFFFFFF;
    @(negedge clk);
    chk_rst_outputs("rst_inflight");
    step();
    @(negedge clk);
    chk_rst_outputs("rst_hold");
    step();
    rst = 1'b0;
    idle(LAT + 2);
    ld(SZ_WORD, 1'b0, 32'h104, 32'h5555AAAA, 1'b0);
    ld(SZ_WORD, 1'b0, 32'h100, 32'hA0000000, 1'b0);
    idle(LAT + 2);

    chk("drain", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
